// File: rtl/wide_add_sequencer.sv
// Sequences one external 32-bit adder over WORDS words, least-significant word first,
// to produce a WORDS*32-bit sum or difference with a one-cycle done pulse.
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_op_sub,
    input  logic                  i_cin,
    input  logic [32*WORDS-1:0]   i_opa,
    input  logic [32*WORDS-1:0]   i_opb,
    output logic [31:0]           o_add_a,
    output logic [31:0]           o_add_b,
    output logic                  o_add_cin,
    input  logic [31:0]           i_add_sum,
    input  logic                  i_add_cout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [32*WORDS-1:0]   o_sum,
    output logic                  o_cout
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_carry;
    logic                     r_cout;
    logic [IDX_W-1:0]         r_idx;
    logic                     w_accept;
    logic                     w_run;
    logic                     w_last;
    logic [WORDS-1:0][31:0]   w_ra_words;
    logic [WORDS-1:0][31:0]   w_rb_words;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        w_last       = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_add_a      = 32'd0;
        o_add_b      = 32'd0;
        o_add_cin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_run     = 1'b1;
                o_busy    = 1'b1;
                o_add_a   = w_ra_words[r_idx];
                o_add_b   = w_rb_words[r_idx];
                o_add_cin = r_carry;
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted once at latch time.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_carry <= i_op_sub | i_cin;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_run) begin
            r_carry <= i_add_cout;
            if (w_last) begin
                r_cout <= i_add_cout;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_cout = r_cout;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] r_ra;
            logic [31:0] r_rb;
            logic [31:0] r_sum;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_ra  <= 32'd0;
                    r_rb  <= 32'd0;
                    r_sum <= 32'd0;
                end else if (w_accept) begin
                    r_ra  <= i_opa[32*gi +: 32];
                    r_rb  <= i_op_sub ? ~i_opb[32*gi +: 32] : i_opb[32*gi +: 32];
                    r_sum <= 32'd0;
                end else if (w_run && (r_idx == IDX_W'(gi))) begin
                    r_sum <= i_add_sum;
                end
            end

            assign w_ra_words[gi]       = r_ra;
            assign w_rb_words[gi]       = r_rb;
            assign o_sum[32*gi +: 32]   = r_sum;
        end
    endgenerate

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: models the external 32-bit adder and checks every
// cycle of directed and random operations against whole-operand arithmetic.
module tb_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           op_sub = 1'b0;
    logic           cin = 1'b0;
    logic [W-1:0]   opa = '0;
    logic [W-1:0]   opb = '0;
    logic [31:0]    add_a;
    logic [31:0]    add_b;
    logic           add_cin;
    logic [31:0]    add_sum;
    logic           add_cout;
    logic           busy;
    logic           done;
    logic [W-1:0]   sum;
    logic           cout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in for the external fulladder_32bits instance.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_op_sub   (op_sub),
        .i_cin      (cin),
        .i_opa      (opa),
        .i_opb      (opb),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_cin  (add_cin),
        .i_add_sum  (add_sum),
        .i_add_cout (add_cout),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum      (sum),
        .o_cout     (cout)
    );

    task automatic check_value(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        int sel;
        sel = $urandom_range(0, 3);
        for (int i = 0; i < WORDS; i++) begin
            v[32*i +: 32] = $urandom();
        end
        if (sel == 0) v = '1;
        if (sel == 1) v = '0;
        return v;
    endfunction

    // Whole-width result: {cout, sum}; for subtract cout is "no borrow".
    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sub, input logic c);
        if (sub) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Carry entering word k, derived from the operands' lower k words only.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub, input logic c, input int k);
        logic [W:0] mask;
        logic [W:0] la;
        logic [W:0] lb;
        logic [W:0] s;
        mask = ({{W{1'b0}}, 1'b1} << (32 * k)) - 1'b1;
        la   = {1'b0, a} & mask;
        lb   = {1'b0, b} & mask;
        if (sub) return (la >= lb);
        s = la + lb + {{W{1'b0}}, c};
        return s[32*k];
    endfunction

    // Entered and left on a negedge with the DUT in IDLE.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic c, input logic hold);
        logic [W:0]  exp;
        logic [31:0] exp_b;
        exp = ref_result(a, b, sub, c);
        check_value("idle_busy", {W'(0), busy}, '0);
        start  = 1'b1;
        opa    = a;
        opb    = b;
        op_sub = sub;
        cin    = c;
        @(negedge clk);
        for (int k = 0; k < WORDS; k++) begin
            start  = hold;
            opa    = rand_wide();
            opb    = rand_wide();
            op_sub = $urandom_range(0, 1);
            cin    = $urandom_range(0, 1);
            exp_b  = sub ? ~b[32*k +: 32] : b[32*k +: 32];
            check_value("run_add_a", {97'd0, add_a}, {97'd0, a[32*k +: 32]});
            check_value("run_add_b", {97'd0, add_b}, {97'd0, exp_b});
            check_value("run_add_cin", {W'(0), add_cin}, {W'(0), carry_into(a, b, sub, c, k)});
            check_value("run_busy", {W'(0), busy}, {W'(0), 1'b1});
            check_value("run_done", {W'(0), done}, '0);
            @(negedge clk);
        end
        check_value("done_pulse", {W'(0), done}, {W'(0), 1'b1});
        check_value("done_busy", {W'(0), busy}, {W'(0), 1'b1});
        check_value("done_sum", {1'b0, sum}, {1'b0, exp[W-1:0]});
        check_value("done_cout", {W'(0), cout}, {W'(0), exp[W]});
        check_value("done_adder_in", {{(W-64){1'b0}}, add_a, add_b, add_cin}, '0);
        @(negedge clk);
        start = 1'b0;
        check_value("post_done", {W'(0), done}, '0);
        check_value("post_busy", {W'(0), busy}, '0);
        check_value("post_sum", {1'b0, sum}, {1'b0, exp[W-1:0]});
        check_value("post_cout", {W'(0), cout}, {W'(0), exp[W]});
        check_value("idle_adder_in", {{(W-64){1'b0}}, add_a, add_b, add_cin}, '0);
        $display("op %s: sub=%0b cin=%0b a=%h b=%h -> cout=%0b sum=%h", name, sub, c, a, b, cout, sum);
    endtask

    task automatic run_abort(input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        opa    = a;
        opb    = b;
        op_sub = 1'b0;
        cin    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_value("abort_busy", {W'(0), busy}, '0);
        check_value("abort_done", {W'(0), done}, '0);
        check_value("abort_sum", {1'b0, sum}, '0);
        check_value("abort_cout", {W'(0), cout}, '0);
        check_value("abort_adder_in", {{(W-64){1'b0}}, add_a, add_b, add_cin}, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_value("abort_no_done", {W'(0), done, busy}, '0);
        end
        $display("abort: reset during RUN, busy=%0b done=%0b sum=%h", busy, done, sum);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset held with start high: reset wins.
        rst_n = 1'b0;
        start = 1'b1;
        opa   = '1;
        opb   = '1;
        repeat (3) @(negedge clk);
        check_value("rst_busy", {W'(0), busy}, '0);
        check_value("rst_done", {W'(0), done}, '0);
        check_value("rst_sum", {1'b0, sum}, '0);
        check_value("rst_cout", {W'(0), cout}, '0);
        check_value("rst_adder_in", {{(W-64){1'b0}}, add_a, add_b, add_cin}, '0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_value("rst_start_dropped", {W'(0), busy}, '0);
        $display("reset: busy=%0b done=%0b sum=%h cout=%0b", busy, done, sum, cout);

        a = '1;
        b = 128'h1;
        run_op("ripple", a, b, 1'b0, 1'b0, 1'b0);
        run_op("cin_only", '0, '0, 1'b0, 1'b1, 1'b0);
        a = 128'hF0000000_00000000_00000000_00000000;
        run_op("top_carry", a, a, 1'b0, 1'b0, 1'b0);
        run_op("sub_borrow", 128'h5, 128'h7, 1'b1, 1'b0, 1'b0);
        run_op("sub_ok", 128'h7, 128'h5, 1'b1, 1'b1, 1'b0);

        // Start held through RUN/DONE, then immediately a second operation.
        run_op("held_start", rand_wide(), rand_wide(), 1'b0, 1'b1, 1'b1);
        run_op("back_to_back", rand_wide(), rand_wide(), 1'b1, 1'b0, 1'b0);

        run_abort(rand_wide(), rand_wide());
        run_op("after_abort", 128'h1234, 128'h0FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            a = rand_wide();
            b = ($urandom_range(0, 5) == 0) ? a : rand_wide();
            run_op("random", a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
